// File: rtl/udl_counter_pkg.sv
// udl_counter_pkg: shared enums for the up/down/load counter
package udl_counter_pkg;
  typedef enum logic {MODE_WRAP = 1'b0, MODE_SAT = 1'b1} count_mode_e;
  typedef enum logic [2:0] {OP_HOLD, OP_CLR, OP_LOAD, OP_UP, OP_DOWN} op_e;
endpackage

// File: rtl/udl_step_unit.sv
// udl_step_unit: next count and boundary flag for one up/down step
module udl_step_unit
  import udl_counter_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] out,
  input  logic [W-1:0] k,
  input  logic [W-1:0] max_val,
  input  count_mode_e  mode,
  input  logic         dn,
  output logic [W-1:0] nxt,
  output logic         evt
);
  logic [W:0] sum;
  logic       oor;
  logic       sat;
  assign sum = {1'b0, out} + {1'b0, k};
  assign oor = out > max_val;
  assign sat = mode == MODE_SAT;
  // every wrapped result is below max_val+1, so W-bit modular arithmetic is exact
  always_comb begin
    evt = oor || (dn ? out < k : sum > {1'b0, max_val});
    nxt = oor ? (sat ? max_val : '0) :
          !dn ? (!evt ? sum[W-1:0] : sat ? max_val : out + k - max_val - W'(1)) :
                (!evt ? out - k : sat ? '0 : out - k + max_val + W'(1));
  end
endmodule

// File: rtl/udl_counter_mod.sv
// udl_counter_mod: modulus up/down/load counter with wrap/saturate, tc pulse and sticky ovf
module udl_counter_mod
  import udl_counter_pkg::*;
#(
  parameter int W = 8,
  parameter int S = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic         load,
  input  logic         up,
  input  logic         down,
  input  logic         mode,
  input  logic [W-1:0] load_val,
  input  logic [S-1:0] step,
  input  logic [W-1:0] max_val,
  input  logic         ovf_clr,
  output logic [W-1:0] out,
  output logic         tc,
  output logic         ovf
);
  op_e         op;
  logic [W-1:0] step_w;
  logic [W-1:0] k;
  logic [W-1:0] nxt;
  logic         evt;
  logic         cnt;
  assign step_w = W'(step);
  // step never exceeds 2^W-1, so max_val+1 fits in W bits whenever it is the smaller
  assign k   = step_w > max_val ? max_val + W'(1) : step_w;
  assign cnt = (op == OP_UP || op == OP_DOWN) && step_w != '0;
  // priority decoder: clr, then load, then a single count direction
  always_comb begin
    op = clr ? OP_CLR : !en ? OP_HOLD : load ? OP_LOAD :
         (up && !down) ? OP_UP : (down && !up) ? OP_DOWN : OP_HOLD;
  end
  udl_step_unit #(.W(W)) u_step (
    .out     (out),
    .k       (k),
    .max_val (max_val),
    .mode    (count_mode_e'(mode)),
    .dn      (op == OP_DOWN),
    .nxt     (nxt),
    .evt     (evt)
  );
  // count, pulse and sticky-flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      out <= op == OP_CLR ? '0 : op == OP_LOAD ? (load_val > max_val ? max_val : load_val) :
             cnt ? nxt : out;
      tc  <= cnt && evt;
      ovf <= (cnt && evt) || (ovf && !ovf_clr);
    end
  end
endmodule
